frame_buffer_dbl: RTL and testbench
===================================

# frame_buffer_dbl

Double-buffered, parametrised pixel store between the renderer (writer) and the display scan-out (reader). Two identical banks. The writer always targets the back bank and the reader always targets the front bank. A swap request exchanges the banks only during vertical blanking, so scan-out never shows a half-drawn frame. An FSM can fill the back bank with a constant colour, one pixel per clock.

## Interface
- H_RES, 320, horizontal resolution in pixels
- V_RES, 240, vertical resolution in lines
- PIX_W, 16, pixel width (RGB565 at default)
- Derived localparams: X_W = clog2(H_RES), Y_W = clog2(V_RES), DEPTH = H_RES*V_RES, ADDR_W = clog2(DEPTH)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe (back bank)
- wr_x  in  X_W  write column
- wr_y  in  Y_W  write line
- wr_data  in  PIX_W  write pixel
- wr_ready  out  1  high when writes are accepted (not clearing)
- rd_en  in  1  read strobe (front bank)
- rd_x  in  X_W  read column
- rd_y  in  Y_W  read line
- rd_data  out  PIX_W  read pixel, registered
- rd_valid  out  1  rd_data qualifies the previous cycle's rd_en
- vblank  in  1  level; display is in vertical blanking
- swap_req  in  1  one-cycle request to swap banks
- swap_pending  out  1  swap latched, not yet performed
- front_sel  out  1  index of the bank currently displayed
- clear_req  in  1  one-cycle request to fill the back bank
- clear_color  in  PIX_W  fill value, sampled on clear_req
- clear_busy  out  1  fill in progress

## Operation
- Address = y*H_RES + x, computed combinationally per port.
- A coordinate is out of range when x ≥ H_RES or y ≥ V_RES.
  - Out-of-range write: dropped.
  - Out-of-range read: rd_data = 0, rd_valid still asserted.
- FSM states: IDLE, CLEAR.
- IDLE → CLEAR on clear_req.
  - Latch clear_color.
  - Clear counter = 0.
- CLEAR: write the latched colour to back[counter] each cycle and increment the counter. When counter = DEPTH-1 is written, return to IDLE.
- During CLEAR:
  - wr_ready = 0 and wr_en is ignored.
  - clear_req is ignored.
- The reader is unaffected by CLEAR because it uses the other bank.
- Swap:
  - swap_req sets swap_pending.
  - A swap fires on the first cycle with swap_pending=1, vblank=1 and state=IDLE. It toggles front_sel and clears swap_pending.
  - Repeated swap_req while pending is idempotent.
- Simultaneous wr_en and swap-fire in one cycle: the write lands in the pre-swap back bank.
- Simultaneous swap_req and clear_req in IDLE: the clear starts and the swap stays pending until the clear completes.
- Reset values:
  - front_sel=0, swap_pending=0, state=IDLE, clear_busy=0, wr_ready=1, rd_data=0, rd_valid=0.
  - RAM contents are not reset.
- rst asserted mid-CLEAR aborts the fill. Bank contents are left partially filled.

## Timing
- Read latency is 1 cycle. rd_en at cycle N gives rd_data/rd_valid at N+1. rd_valid=0 otherwise and rd_data holds its last value.
- A read uses the front_sel value present at cycle N. A swap at N affects reads issued from N+1.
- A write at cycle N is visible to a read of the same bank issued at N+1 or later.
- clear_busy rises the cycle after clear_req and stays high for exactly DEPTH cycles (76 800 at defaults).
- A swap fires at the earliest one cycle after swap_req (registered pending) or after clear_busy falls.

## Structure
- Package fb_pkg:
  - FSM state enum (FB_IDLE, FB_CLEAR).
  - Default H_RES/V_RES/PIX_W constants.
  - clog2-based width helpers.
- Sub-module fb_bank (parameters DEPTH, PIX_W):
  - Simple dual-port RAM, one write port, one registered read port.
  - Inferable as BRAM.
  - Instantiated twice.
  - Top-level muxes write/read ports by front_sel.

## Test plan
- Write (10,20)=0xF800 with front_sel=0. Swap in vblank, then read (10,20) → 0xF800 one cycle after rd_en, rd_valid=1.
- Write to (320,0) and (0,240). Reads of both → 0x0000. Back-bank contents remain unchanged.
- clear_req with color 0x07E0. clear_busy is high for 76 800 cycles and wr_ready=0 throughout. After swap, reads at (0,0) and (319,239) → 0x07E0.
- swap_req with vblank=0 for 100 cycles: swap_pending=1 and front_sel is unchanged. Raise vblank: front_sel toggles that cycle and swap_pending → 0.
- swap_req during CLEAR with vblank=1: no swap until clear_busy falls, then the swap fires the next eligible cycle.
- Assert rst at clear counter 500: all outputs go to reset values the next cycle. A new clear_req afterwards runs a full DEPTH-cycle fill.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the double-buffered frame store.
package fb_pkg;

    localparam int FB_H_RES_DEF = 320;
    localparam int FB_V_RES_DEF = 240;
    localparam int FB_PIX_W_DEF = 16;

    typedef enum logic {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int fb_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM with a registered read port.
module fb_bank
    import fb_pkg::*;
#(
    parameter int DEPTH  = FB_H_RES_DEF * FB_V_RES_DEF,
    parameter int PIX_W  = FB_PIX_W_DEF,
    parameter int ADDR_W = fb_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rdata_q;

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame store: writer owns the back bank, scan-out owns the
// front bank, banks exchange only in vertical blanking, and a fill engine can
// paint the back bank with a constant colour.
module frame_buffer_dbl
    import fb_pkg::*;
#(
    parameter int H_RES = FB_H_RES_DEF,
    parameter int V_RES = FB_V_RES_DEF,
    parameter int PIX_W = FB_PIX_W_DEF,
    localparam int X_W    = fb_width(H_RES),
    localparam int Y_W    = fb_width(V_RES),
    localparam int DEPTH  = H_RES * V_RES,
    localparam int ADDR_W = fb_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             vblank,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             front_sel,
    input  logic             clear_req,
    input  logic [PIX_W-1:0] clear_color,
    output logic             clear_busy
);

    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [X_W:0]      X_LIM   = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0]      Y_LIM   = (Y_W + 1)'(V_RES);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0]  color_q, color_d;
    logic              front_sel_q, front_sel_d;
    logic              swap_pending_q, swap_pending_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_zero_q, rd_zero_d;
    logic              rd_bank_q, rd_bank_d;

    logic              wr_in, rd_in, swap_fire;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              back_we;
    logic [ADDR_W-1:0] back_waddr;
    logic [PIX_W-1:0]  back_wdata;
    logic [1:0]        bank_we, bank_re;
    logic [PIX_W-1:0]  bank_rdata [2];

    // Per-port linear address and range qualification.
    always_comb begin
        wr_in   = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
        rd_in   = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
        wr_addr = ADDR_W'(wr_y) * H_RES_A + ADDR_W'(wr_x);
        rd_addr = ADDR_W'(rd_y) * H_RES_A + ADDR_W'(rd_x);
    end

    // Fill FSM next state and ownership of the back-bank write port.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        back_we    = 1'b0;
        back_waddr = wr_addr;
        back_wdata = wr_data;
        case (state_q)
            FB_IDLE: begin
                back_we = wr_en && wr_in;
                if (clear_req) begin
                    state_d = FB_CLEAR;
                    cnt_d   = '0;
                    color_d = clear_color;
                end
            end
            FB_CLEAR: begin
                back_we    = 1'b1;
                back_waddr = cnt_q;
                back_wdata = color_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_A) state_d = FB_IDLE;
            end
            default: state_d = FB_IDLE;
        endcase
    end

    // Swap only when idle in blanking; a write in the firing cycle still uses the old back bank.
    always_comb begin
        swap_fire      = swap_pending_q && vblank && (state_q == FB_IDLE);
        swap_pending_d = swap_fire ? 1'b0 : (swap_pending_q || swap_req);
        front_sel_d    = front_sel_q ^ swap_fire;
    end

    // Read pipeline bookkeeping; bank and zero flag hold between reads so rd_data holds.
    always_comb begin
        rd_valid_d = rd_en;
        rd_zero_d  = rd_zero_q;
        rd_bank_d  = rd_bank_q;
        if (rd_en) begin
            rd_zero_d = !rd_in;
            rd_bank_d = front_sel_q;
        end
        bank_we = back_we ? (front_sel_q ? 2'b01 : 2'b10) : 2'b00;
        bank_re = (rd_en && rd_in) ? (front_sel_q ? 2'b10 : 2'b01) : 2'b00;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FB_IDLE;
            cnt_q          <= '0;
            color_q        <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_zero_q      <= 1'b1;
            rd_bank_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            color_q        <= color_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            rd_valid_q     <= rd_valid_d;
            rd_zero_q      <= rd_zero_d;
            rd_bank_q      <= rd_bank_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fb_bank #(
            .DEPTH (DEPTH),
            .PIX_W (PIX_W),
            .ADDR_W(ADDR_W)
        ) u_bank (
            .clk  (clk),
            .we   (bank_we[b]),
            .waddr(back_waddr),
            .wdata(back_wdata),
            .re   (bank_re[b]),
            .raddr(rd_addr),
            .rdata(bank_rdata[b])
        );
    end

    assign rd_data      = rd_zero_q ? '0 : bank_rdata[rd_bank_q];
    assign rd_valid     = rd_valid_q;
    assign wr_ready     = (state_q == FB_IDLE);
    assign clear_busy   = (state_q == FB_CLEAR);
    assign swap_pending = swap_pending_q;
    assign front_sel    = front_sel_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Bench for frame_buffer_dbl at a reduced 20x10 resolution.
module tb_frame_buffer_dbl;

    localparam int H  = 20;
    localparam int V  = 10;
    localparam int PW = 16;
    localparam int XW = 5;
    localparam int YW = 4;
    localparam int D  = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, vblank, swap_req, clear_req;
    logic [XW-1:0] wr_x, rd_x;
    logic [YW-1:0] wr_y, rd_y;
    logic [PW-1:0] wr_data, clear_color, rd_data;
    logic          wr_ready, rd_valid, swap_pending, front_sel, clear_busy;

    always #5 clk = ~clk;

    frame_buffer_dbl #(.H_RES(H), .V_RES(V), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
        .vblank(vblank), .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference: two pixel arrays, which one is displayed, pending swap, fill progress.
    logic [PW-1:0] mem [2][D];
    int            m_front = 0;
    int            m_pend  = 0;
    int            m_left  = 0;
    int            m_idx   = 0;
    logic [PW-1:0] m_color = '0;
    logic [PW-1:0] m_rd    = '0;
    logic          m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit busy;
        bit fire;
        if (rst) begin
            m_front = 0; m_pend = 0; m_left = 0; m_rd = '0; m_valid = 1'b0;
        end else begin
            busy    = (m_left > 0);
            m_valid = rd_en;
            if (rd_en) m_rd = (rd_x < H && rd_y < V) ? mem[m_front][rd_y * H + rd_x] : '0;
            if (!busy && wr_en && wr_x < H && wr_y < V) mem[1 - m_front][wr_y * H + wr_x] = wr_data;
            if (busy) begin
                mem[1 - m_front][m_idx] = m_color;
                m_idx++;
                m_left--;
            end
            fire = (m_pend != 0) && vblank && !busy;
            if (fire) begin
                m_front = 1 - m_front;
                m_pend  = 0;
            end else if (swap_req) begin
                m_pend = 1;
            end
            if (!busy && clear_req) begin
                m_left = D; m_idx = 0; m_color = clear_color;
            end
        end
        @(posedge clk);
        #1;
        check("rd_valid", rd_valid, m_valid);
        check("rd_data", rd_data, m_rd);
        check("front_sel", front_sel, m_front);
        check("swap_pending", swap_pending, m_pend);
        check("clear_busy", clear_busy, m_left > 0);
        check("wr_ready", wr_ready, m_left == 0);
    endtask

    task automatic do_write(input int x, input int y, input logic [PW-1:0] d);
        wr_en = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int x, input int y, input logic [PW-1:0] exp);
        rd_en = 1'b1; rd_x = XW'(x); rd_y = YW'(y);
        cycle();
        rd_en = 1'b0;
        check("dir_rd_valid", rd_valid, 1);
        check("dir_rd_data", rd_data, exp);
    endtask

    task automatic do_swap();
        logic f0;
        f0 = front_sel;
        vblank = 1'b1; swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        cycle();
        vblank = 1'b0;
        check("dir_swap", front_sel, !f0);
    endtask

    // Fill while hammering wr_en, which must be ignored; count busy cycles.
    task automatic do_clear(input logic [PW-1:0] color);
        int n;
        clear_req = 1'b1; clear_color = color;
        cycle();
        clear_req = 1'b0;
        wr_en = 1'b1; wr_x = '0; wr_y = '0; wr_data = ~color;
        n = 0;
        while (clear_busy === 1'b1 && n < D + 20) begin
            n++;
            cycle();
        end
        wr_en = 1'b0;
        check("clear_len", n, D);
    endtask

    initial begin
        logic f0;
        int   n;
        rst = 1'b1; wr_en = 0; rd_en = 0; vblank = 0; swap_req = 0; clear_req = 0;
        wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0; wr_data = '0; clear_color = '0;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_front", front_sel, 0);
        check("rst_pending", swap_pending, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);

        // Put both banks into a known state.
        do_clear(16'h1111);
        do_swap();
        do_clear(16'h2222);
        do_swap();

        // Write to back, swap, read it from the front.
        do_write(10, 5, 16'hF800);
        do_swap();
        do_read(10, 5, 16'hF800);
        do_read(0, 0, 16'h1111);

        // Out-of-range writes dropped, out-of-range reads give zero.
        do_write(20, 0, 16'hABCD);
        do_write(0, 10, 16'h1234);
        do_read(20, 0, 16'h0000);
        do_read(0, 10, 16'h0000);
        do_swap();
        do_read(0, 1, 16'h2222);
        do_read(19, 9, 16'h2222);

        // Fill, swap, check corners.
        do_clear(16'h07E0);
        do_swap();
        do_read(0, 0, 16'h07E0);
        do_read(19, 9, 16'h07E0);

        // Swap held off outside blanking.
        f0 = front_sel;
        swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        for (int i = 0; i < 100; i++) cycle();
        check("hold_pending", swap_pending, 1);
        check("hold_front", front_sel, f0);
        vblank = 1'b1;
        cycle();
        vblank = 1'b0;
        check("vblank_front", front_sel, !f0);
        check("vblank_pending", swap_pending, 0);

        // Swap requested during a fill waits for the fill to finish.
        f0 = front_sel;
        clear_req = 1'b1; clear_color = 16'h3333;
        cycle();
        clear_req = 1'b0;
        vblank = 1'b1; swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
        n = 0;
        while (clear_busy === 1'b1 && n < D + 20) begin
            n++;
            cycle();
        end
        check("fill_swap_wait", front_sel, f0);
        check("fill_swap_pend", swap_pending, 1);
        cycle();
        vblank = 1'b0;
        check("fill_swap_fire", front_sel, !f0);
        do_read(5, 5, 16'h3333);

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            wr_en     = 1'($urandom % 2);
            wr_x      = XW'($urandom_range(0, H + 3));
            wr_y      = YW'($urandom_range(0, V + 1));
            wr_data   = PW'($urandom);
            rd_en     = 1'($urandom % 2);
            rd_x      = XW'($urandom_range(0, H + 3));
            rd_y      = YW'($urandom_range(0, V + 1));
            vblank    = ($urandom % 4) == 0;
            swap_req  = ($urandom % 16) == 0;
            clear_req = ($urandom % 256) == 0;
            clear_color = PW'($urandom);
            cycle();
        end
        wr_en = 0; rd_en = 0; vblank = 0; swap_req = 0; clear_req = 0;
        n = 0;
        while (clear_busy === 1'b1 && n < D + 20) begin
            n++;
            cycle();
        end

        // Reset partway through a fill, then a full fill afterwards.
        clear_req = 1'b1; clear_color = 16'h0F0F;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", clear_busy, 0);
        check("abort_ready", wr_ready, 1);
        check("abort_front", front_sel, 0);
        check("abort_pending", swap_pending, 0);
        check("abort_rd_valid", rd_valid, 0);
        check("abort_rd_data", rd_data, 0);
        do_clear(16'h5A5A);
        do_swap();
        do_read(0, 0, 16'h5A5A);
        do_read(19, 9, 16'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
